// File: rtl/uart_mmio_responder.sv
// Memory-mapped UART (8N1, or 8E1 when UART_PARITY_EN is defined) answering CPU loads/stores
// in a 16-byte window at BASE_ADDR: TXDATA, RXDATA, STATUS (W1C flags), BAUDDIV.
module uart_mmio_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h40000020,
    parameter logic [15:0] DIV_RESET = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Read_data,
    output logic        hit,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic        irq
);

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_RXDATA  = 2'd1;
    localparam logic [1:0] OFF_STATUS  = 2'd2;
    localparam logic [1:0] OFF_BAUDDIV = 2'd3;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
`else
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif

    // Bus strobes: MemRead/MemWrite are single-cycle qualifiers with no ready/stall.
    // An access completes on the rising edge it is presented on; load data is
    // combinational in that same cycle and reflects the state before the edge.
    logic [1:0]  offset;
    logic        wr_hit;
    logic        rd_hit;
    logic        pop;
    logic [31:0] w1c;

    assign hit    = (Address[31:4] == BASE_ADDR[31:4]);
    assign offset = Address[3:2];
    assign wr_hit = hit && MemWrite;
    assign rd_hit = hit && MemRead;
    assign pop    = rd_hit && (offset == OFF_RXDATA);
    assign w1c    = (wr_hit && (offset == OFF_STATUS)) ? Write_data : 32'b0;

    logic unused_bits;
    assign unused_bits = ^{Address[1:0], Write_data[31:16]};

    logic [15:0] div_q;

    // ---------------- TX ----------------
    tx_state_t   tx_state;
    tx_state_t   tx_state_d;
    logic [15:0] tx_cnt;
    logic [15:0] tx_div;
    logic [7:0]  tx_shift;
    logic [2:0]  tx_bit;
    logic        tx_tick;
    logic        tx_busy;
    logic        tx_store;
    logic        tx_load;
`ifdef UART_PARITY_EN
    logic        tx_par;
`endif

    assign tx_busy  = (tx_state != TX_IDLE);
    assign tx_store = wr_hit && (offset == OFF_TXDATA);
    assign tx_load  = tx_store && !tx_busy;
    assign tx_tick  = (tx_cnt == tx_div - 16'd1);

    always_comb begin
        tx_state_d = tx_state;
        uart_tx    = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (tx_load) tx_state_d = TX_START;
            end
            TX_START: begin
                uart_tx = 1'b0;
                if (tx_tick) tx_state_d = TX_DATA;
            end
            TX_DATA: begin
                uart_tx = tx_shift[0];
                if (tx_tick && (tx_bit == 3'd7)) begin
`ifdef UART_PARITY_EN
                    tx_state_d = TX_PARITY;
`else
                    tx_state_d = TX_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                uart_tx = tx_par;
                if (tx_tick) tx_state_d = TX_STOP;
            end
`endif
            TX_STOP: begin
                if (tx_tick) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= 16'd0;
            tx_div   <= DIV_RESET;
            tx_shift <= 8'd0;
            tx_bit   <= 3'd0;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_d;
            if (tx_state == TX_IDLE) begin
                tx_cnt <= 16'd0;
                tx_bit <= 3'd0;
                // The divisor is captured here so a BAUDDIV write cannot stretch an in-flight frame.
                if (tx_load) begin
                    tx_shift <= Write_data[7:0];
                    tx_div   <= div_q;
`ifdef UART_PARITY_EN
                    tx_par   <= ^Write_data[7:0];
`endif
                end
            end else if (tx_tick) begin
                tx_cnt <= 16'd0;
                if (tx_state == TX_DATA) begin
                    tx_shift <= {1'b0, tx_shift[7:1]};
                    tx_bit   <= tx_bit + 3'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

    // ---------------- RX ----------------
    rx_state_t   rx_state;
    rx_state_t   rx_state_d;
    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    logic        rx_fall;
    logic [15:0] rx_cnt;
    logic [15:0] rx_div;
    logic [15:0] rx_half;
    logic [7:0]  rx_shift;
    logic [2:0]  rx_bit;
    logic        rx_tick;
    logic        rx_stop_hit;
    logic        rx_frame_bad;
    logic        rx_par_fail;
    logic        rx_done;
`ifdef UART_PARITY_EN
    logic        rx_par_bad;
`endif

    assign rx_fall = rx_prev && !rx_sync;
    assign rx_half = {1'b0, rx_div[15:1]};
    // START waits half a bit so every later sample lands near mid-bit.
    assign rx_tick = (rx_state == RX_START) ? (rx_cnt == rx_half - 16'd1)
                                            : (rx_cnt == rx_div - 16'd1);

    assign rx_stop_hit  = (rx_state == RX_STOP) && rx_tick;
    assign rx_frame_bad = rx_stop_hit && !rx_sync;
`ifdef UART_PARITY_EN
    assign rx_par_fail  = rx_stop_hit && rx_sync && rx_par_bad;
`else
    assign rx_par_fail  = 1'b0;
`endif
    assign rx_done      = rx_stop_hit && rx_sync && !rx_par_fail;

    always_comb begin
        rx_state_d = rx_state;
        case (rx_state)
            RX_IDLE: begin
                if (rx_fall) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_tick) rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (rx_tick && (rx_bit == 3'd7)) begin
`ifdef UART_PARITY_EN
                    rx_state_d = RX_PARITY;
`else
                    rx_state_d = RX_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rx_tick) rx_state_d = RX_STOP;
            end
`endif
            RX_STOP: begin
                if (rx_tick) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= 16'd0;
            rx_div   <= DIV_RESET;
            rx_shift <= 8'd0;
            rx_bit   <= 3'd0;
`ifdef UART_PARITY_EN
            rx_par_bad <= 1'b0;
`endif
        end else begin
            rx_meta  <= uart_rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_d;
            if (rx_state == RX_IDLE) begin
                rx_cnt <= 16'd0;
                rx_bit <= 3'd0;
                if (rx_fall) rx_div <= div_q;
            end else if (rx_tick) begin
                rx_cnt <= 16'd0;
                if (rx_state == RX_DATA) begin
                    rx_shift <= {rx_sync, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 3'd1;
                end
`ifdef UART_PARITY_EN
                if (rx_state == RX_PARITY) rx_par_bad <= rx_sync ^ (^rx_shift);
`endif
            end else begin
                rx_cnt <= rx_cnt + 16'd1;
            end
        end
    end

    // ---------------- registers and flags ----------------
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_overrun;
    logic       tx_lost;
    logic       frame_err;
    logic       parity_err;

    // Flag updates are (old & ~clear) | set, so a set on the clearing edge survives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q      <= DIV_RESET;
            rx_byte    <= 8'd0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            tx_lost    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (wr_hit && (offset == OFF_BAUDDIV))
                div_q <= (Write_data[15:0] < 16'd2) ? 16'd2 : Write_data[15:0];

            if (rx_done && (!rx_valid || pop)) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (pop) begin
                rx_valid <= 1'b0;
            end

            rx_overrun <= (rx_overrun & ~w1c[2]) | (rx_done && rx_valid && !pop);
            tx_lost    <= (tx_lost    & ~w1c[3]) | (tx_store && tx_busy);
            frame_err  <= (frame_err  & ~w1c[4]) | rx_frame_bad;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) parity_err <= 1'b0;
        else        parity_err <= (parity_err & ~w1c[5]) | rx_par_fail;
    end
`else
    assign parity_err = 1'b0;
`endif

    assign irq = rx_valid;

    always_comb begin
        Read_data = 32'b0;
        if (rd_hit) begin
            case (offset)
                OFF_RXDATA:  Read_data = {24'b0, rx_byte};
                OFF_STATUS:  Read_data = {26'b0, parity_err, frame_err, tx_lost,
                                          rx_overrun, rx_valid, tx_busy};
                OFF_BAUDDIV: Read_data = {16'b0, div_q};
                default:     Read_data = 32'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Directed bench for uart_mmio_responder: bus register access, TX framing, RX
// reception, overrun/pop race, frame error, glitch rejection and mid-frame reset.
module tb_uart_mmio_responder;

    localparam logic [31:0] BASE = 32'h40000020;
    localparam logic [31:0] A_TX = BASE;
    localparam logic [31:0] A_RX = BASE + 32'd4;
    localparam logic [31:0] A_ST = BASE + 32'd8;
    localparam logic [31:0] A_BD = BASE + 32'd12;
    localparam int DIV = 4;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Read_data;
    logic        hit;
    logic        uart_tx;
    logic        uart_rx;
    logic        irq;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [10:0] tx_frame;
`ifdef UART_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_mmio_responder dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Read_data  (Read_data),
        .hit        (hit),
        .uart_tx    (uart_tx),
        .uart_rx    (uart_rx),
        .irq        (irq)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- drivers (entered and left on a negedge) ----------------
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        Address    = addr;
        Write_data = data;
        MemWrite   = 1'b1;
        @(negedge clk);
        MemWrite   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input string tag, input logic [31:0] exp);
        Address = addr;
        MemRead = 1'b1;
        #1 check(tag, Read_data, exp);
        @(negedge clk);
        MemRead = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop_bit);
        logic [10:0] frame;
        frame      = '1;
        frame[0]   = 1'b0;
        frame[8:1] = b;
`ifdef UART_PARITY_EN
        frame[9]   = (^b) ^ par_flip;
`endif
        frame[NBITS-1] = stop_bit;
        for (int i = 0; i < NBITS; i++) begin
            uart_rx = frame[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Address    = 32'd0;
        Write_data = 32'd0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        uart_rx    = 1'b1;
        reset      = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        bus_read(A_ST, "rst_status", 32'd0);
        bus_read(A_BD, "rst_bauddiv", 32'd868);
        bus_read(A_RX, "rst_rxdata", 32'd0);

        // decode window
        Address = BASE + 32'd16;
        MemRead = 1'b1;
        #1;
        check("miss_hit", 32'(hit), 32'd0);
        check("miss_rdata", Read_data, 32'd0);
        Address = A_BD;
        #1;
        check("hit_hit", 32'(hit), 32'd1);
        @(negedge clk);
        MemRead = 1'b0;

        // divisor clamp, then simultaneous read+write returns pre-write value
        bus_write(A_BD, 32'd1);
        bus_read(A_BD, "div_clamp", 32'd2);
        Address    = A_BD;
        Write_data = 32'd4;
        MemWrite   = 1'b1;
        MemRead    = 1'b1;
        #1 check("rw_old_value", Read_data, 32'd2);
        @(negedge clk);
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        bus_read(A_BD, "div_new", 32'd4);

        // TX frame 0xA5 with a colliding store of 0x3C mid-frame
`ifdef UART_PARITY_EN
        tx_frame = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
        tx_frame = {1'b0, 1'b1, 8'hA5, 1'b0};
`endif
        bus_write(A_TX, 32'h000000A5);
        for (int c = 0; c <= NBITS * DIV; c++) begin
            if (c == 10) begin
                Address    = A_TX;
                Write_data = 32'h0000003C;
                MemWrite   = 1'b1;
                MemRead    = 1'b0;
            end else begin
                Address  = A_ST;
                MemWrite = 1'b0;
                MemRead  = 1'b1;
            end
            #1;
            if (c < NBITS * DIV) begin
                check($sformatf("tx_line_c%0d", c), 32'(uart_tx), 32'(tx_frame[c / DIV]));
                if (c != 10) check($sformatf("tx_busy_c%0d", c), 32'(Read_data[0]), 32'd1);
            end else begin
                check("tx_line_idle", 32'(uart_tx), 32'd1);
                check("tx_busy_done", 32'(Read_data[0]), 32'd0);
            end
            @(negedge clk);
        end
        MemRead = 1'b0;
        bus_read(A_ST, "tx_lost_set", 32'h8);
        bus_write(A_ST, 32'h8);
        bus_read(A_ST, "tx_lost_clr", 32'h0);

        // single RX frame
        rx_send(8'h5A, 1'b1);
        exp_q.push_back(32'h5A);
        @(negedge clk);
        check("rx_irq_set", 32'(irq), 32'd1);
        bus_read(A_ST, "rx_status", 32'h2);
        bus_read(A_RX, "rx_data_5a", exp_q.pop_front());
        bus_read(A_ST, "rx_popped", 32'h0);
        check("rx_irq_clr", 32'(irq), 32'd0);

        // overrun, then pop on the completion edge of a third frame
        rx_send(8'h11, 1'b1);
        exp_q.push_back(32'h11);
        rx_send(8'h22, 1'b1);
        @(negedge clk);
        bus_read(A_ST, "ovr_status", 32'h6);
        bus_write(A_ST, 32'h4);
        bus_read(A_ST, "ovr_clr", 32'h2);
        rx_send(8'h33, 1'b1);
        exp_q.push_back(32'h33);
        bus_read(A_RX, "pop_race_old", exp_q.pop_front());
        bus_read(A_ST, "pop_race_status", 32'h2);
        bus_read(A_RX, "pop_race_new", exp_q.pop_front());
        bus_read(A_ST, "pop_race_empty", 32'h0);

        // stop bit low -> frame error, byte dropped
        rx_send(8'h77, 1'b0);
        @(negedge clk);
        bus_read(A_ST, "frame_err", 32'h10);
        check("frame_err_irq", 32'(irq), 32'd0);
        bus_write(A_ST, 32'h10);
        bus_read(A_ST, "frame_err_clr", 32'h0);

`ifdef UART_PARITY_EN
        par_flip = 1'b1;
        rx_send(8'h5A, 1'b1);
        @(negedge clk);
        bus_read(A_ST, "parity_err", 32'h20);
        bus_write(A_ST, 32'h20);
        rx_send(8'h5A, 1'b0);
        par_flip = 1'b0;
        @(negedge clk);
        bus_read(A_ST, "frame_over_parity", 32'h10);
        bus_write(A_ST, 32'h10);
        bus_read(A_ST, "parity_clr", 32'h0);
`endif

        // one-clock glitch is rejected, receiver still works afterwards
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (8) @(negedge clk);
        bus_read(A_ST, "glitch_status", 32'h0);
        check("glitch_irq", 32'(irq), 32'd0);
        rx_send(8'hC3, 1'b1);
        @(negedge clk);
        bus_read(A_RX, "after_glitch", 32'hC3);

        // reset in the middle of a TX frame
        bus_write(A_TX, 32'h00000000);
        repeat (6) @(negedge clk);
        check("midtx_low", 32'(uart_tx), 32'd0);
        reset = 1'b0;
        #1;
        check("midtx_reset_line", 32'(uart_tx), 32'd1);
        check("midtx_reset_irq", 32'(irq), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus_read(A_ST, "post_rst_status", 32'h0);
        bus_read(A_BD, "post_rst_div", 32'd868);
        check("post_rst_line", 32'(uart_tx), 32'd1);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
